// File: rtl/sample_frame_collector.sv
// Collects a serial signed sample stream into NUM_INPUT-wide frames, zero padded on early close.
// Valid/ready on both sides; a frame is presented one cycle after its closing sample is accepted.
module sample_frame_collector #(
    parameter int NUM_INPUT = 4,
    parameter int WIDTH_IN  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [WIDTH_IN-1:0] s_data,
    input  logic                       s_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic signed [WIDTH_IN-1:0] m_data [NUM_INPUT],
    output logic [$clog2(NUM_INPUT+1)-1:0] m_count
);

    localparam int IDX_W = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;
    localparam int CNT_W = $clog2(NUM_INPUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUT - 1);

    if (NUM_INPUT < 1 || WIDTH_IN <= 0) begin : g_bad_params
        $error("sample_frame_collector: NUM_INPUT must be >= 1 and WIDTH_IN > 0");
    end

    typedef enum logic {FILL, FULL} state_t;

    state_t                      state, state_nxt;
    logic [IDX_W-1:0]            idx, idx_nxt;
    logic [CNT_W-1:0]            count, count_nxt;
    logic signed [WIDTH_IN-1:0]  slot     [NUM_INPUT];
    logic signed [WIDTH_IN-1:0]  slot_nxt [NUM_INPUT];

    logic accept;
    logic handoff;
    logic closing;

    assign s_ready = !rst && ((state == FILL) || m_ready);
    assign m_valid = (state == FULL);
    assign accept  = s_valid && s_ready;
    assign handoff = m_valid && m_ready;
    // idx is always 0 while FULL, so this also covers the handoff+accept restart.
    assign closing = accept && (s_last || (idx == LAST_IDX));

    assign m_data  = slot;
    assign m_count = count;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        count_nxt = count;
        slot_nxt  = slot;
        case (state)
            FILL: begin
                if (accept) begin
                    slot_nxt[idx] = s_data;
                    if (closing) begin
                        state_nxt = FULL;
                        count_nxt = CNT_W'(idx) + CNT_W'(1);
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            FULL: begin
                if (handoff) begin
                    for (int i = 0; i < NUM_INPUT; i++) slot_nxt[i] = '0;
                    state_nxt = FILL;
                    count_nxt = '0;
                    idx_nxt   = '0;
                    // Old frame leaves and the new one starts in slot 0 in the same cycle.
                    if (accept) begin
                        slot_nxt[0] = s_data;
                        if (closing) begin
                            state_nxt = FULL;
                            count_nxt = CNT_W'(1);
                        end else begin
                            idx_nxt = IDX_W'(1);
                        end
                    end
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            idx   <= '0;
            count <= '0;
            for (int i = 0; i < NUM_INPUT; i++) slot[i] <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            count <= count_nxt;
            slot  <= slot_nxt;
        end
    end

endmodule

// File: tb/tb_sample_frame_collector.sv
// Drives one shared stream into a 4-wide and a 1-wide collector and compares every cycle
// against a frame-level model built from the accept/close/handoff rules.
module tb_sample_frame_collector;

    logic clk = 1'b0;
    logic rst;
    logic s_valid;
    logic s_last;
    logic m_ready;
    logic signed [15:0] s_data;

    logic               s_ready0, m_valid0;
    logic signed [15:0] m_data0 [4];
    logic [2:0]         m_count0;
    logic               s_ready1, m_valid1;
    logic signed [15:0] m_data1 [1];
    logic [0:0]         m_count1;

    int n_checks = 0;
    int n_errors = 0;

    // Model: partial frame being gathered and the frame currently offered downstream.
    int part [2][4];
    int plen [2];
    int frm  [2][4];
    int flen [2];
    bit have [2];
    int width_of [2] = '{4, 1};

    always #5 clk = ~clk;

    sample_frame_collector #(.NUM_INPUT(4), .WIDTH_IN(16)) dut4 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
        .s_last(s_last), .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0),
        .m_count(m_count0)
    );

    sample_frame_collector #(.NUM_INPUT(1), .WIDTH_IN(16)) dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
        .s_last(s_last), .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1),
        .m_count(m_count1)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_ready(input int d);
        return (rst || (have[d] && !m_ready)) ? 0 : 1;
    endfunction

    function automatic int exp_slot(input int d, input int i);
        return (i < flen[d]) ? frm[d][i] : 0;
    endfunction

    task automatic compare_all();
        check_val("s_ready4", int'(s_ready0), exp_ready(0));
        check_val("m_valid4", int'(m_valid0), int'(have[0]));
        check_val("m_count4", int'(m_count0), have[0] ? flen[0] : 0);
        if (have[0]) begin
            for (int i = 0; i < 4; i++)
                check_val($sformatf("m_data4[%0d]", i), int'(m_data0[i]), exp_slot(0, i));
        end
        check_val("s_ready1", int'(s_ready1), exp_ready(1));
        check_val("m_valid1", int'(m_valid1), int'(have[1]));
        check_val("m_count1", int'(m_count1), have[1] ? flen[1] : 0);
        if (have[1]) check_val("m_data1[0]", int'(m_data1[0]), exp_slot(1, 0));
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            have[d] = 1'b0;
            plen[d] = 0;
            flen[d] = 0;
        end
    endtask

    task automatic update_model();
        bit acc, hand;
        int v;
        if (rst) begin
            model_reset();
            return;
        end
        v = int'(s_data);
        for (int d = 0; d < 2; d++) begin
            acc  = s_valid && (!have[d] || m_ready);
            hand = have[d] && m_ready;
            if (hand) begin
                have[d] = 1'b0;
                flen[d] = 0;
            end
            if (acc) begin
                part[d][plen[d]] = v;
                plen[d]++;
                if (s_last || plen[d] == width_of[d]) begin
                    for (int i = 0; i < 4; i++) frm[d][i] = part[d][i];
                    flen[d] = plen[d];
                    plen[d] = 0;
                    have[d] = 1'b1;
                end
            end
        end
    endtask

    task automatic drive(input bit v, input int d, input bit l, input bit mr, input bit r);
        s_valid = v;
        s_data  = 16'(d);
        s_last  = l;
        m_ready = mr;
        rst     = r;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        update_model();
        #1;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        drive(0, 0, 0, 1, 1);

        // Four back-to-back samples fill one frame.
        for (int v = 1; v <= 4; v++) drive(1, v, 0, 1, 0);
        check_val("t1_slot0", int'(m_data0[0]), 1);
        check_val("t1_slot3", int'(m_data0[3]), 4);
        check_val("t1_count", int'(m_count0), 4);
        drive(0, 0, 0, 1, 0);
        check_val("t1_single_valid", int'(m_valid0), 0);

        // Early close pads with zeros.
        drive(1, -5, 0, 1, 0);
        drive(1, 7, 1, 1, 0);
        check_val("t2_slot0", int'(m_data0[0]), -5);
        check_val("t2_slot1", int'(m_data0[1]), 7);
        check_val("t2_slot2", int'(m_data0[2]), 0);
        check_val("t2_slot3", int'(m_data0[3]), 0);
        check_val("t2_count", int'(m_count0), 2);
        drive(0, 0, 0, 1, 0);

        // Held frame under backpressure, then handoff with a concurrent accept.
        for (int v = 10; v <= 13; v++) drive(1, v, 0, 0, 0);
        for (int k = 0; k < 3; k++) drive(1, 77, 0, 0, 0);
        drive(1, 9, 0, 1, 0);
        check_val("t3_after_valid", int'(m_valid0), 0);
        check_val("t3_after_slot0", int'(m_data0[0]), 9);
        for (int v = 1; v <= 3; v++) drive(1, v, 0, 1, 0);
        check_val("t3_next_slot0", int'(m_data0[0]), 9);

        // Continuous streaming with no bubbles.
        for (int v = 0; v < 12; v++) drive(1, v, 0, 1, 0);
        drive(0, 0, 0, 1, 0);

        // Reset mid-fill discards the partial frame.
        drive(1, 100, 0, 1, 0);
        drive(1, 200, 0, 1, 0);
        drive(0, 0, 0, 1, 1);
        for (int v = 1; v <= 4; v++) drive(1, v, 0, 1, 0);
        check_val("t5_slot0", int'(m_data0[0]), 1);
        check_val("t5_slot1", int'(m_data0[1]), 2);
        drive(0, 0, 0, 1, 0);

        // Single-slot collector: one frame per sample, held under backpressure.
        drive(1, 5, 0, 1, 0);
        check_val("t6_a", int'(m_data1[0]), 5);
        drive(1, -6, 0, 1, 0);
        check_val("t6_b", int'(m_data1[0]), -6);
        drive(1, 7, 0, 1, 0);
        check_val("t6_c", int'(m_data1[0]), 7);
        drive(1, 8, 0, 0, 0);
        drive(1, 9, 0, 0, 0);
        check_val("t6_hold_data", int'(m_data1[0]), 7);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);

        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 9) < 7), int'($urandom_range(0, 65535)) - 32768,
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 49) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
